// File: rtl/systolic_feeder.sv
// Systolic array feeder: captures a 4x4 A and a 4x4 B over four load beats,
// then streams them diagonally skewed into the west and north edges of a
// 4x4 array for seven cycles, followed by a configurable drain phase.
module systolic_feeder #(
    parameter int DRAIN_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a0,
    input  logic [31:0] a1,
    input  logic [31:0] a2,
    input  logic [31:0] a3,
    input  logic [31:0] b0,
    input  logic [31:0] b1,
    input  logic [31:0] b2,
    input  logic [31:0] b3,
    output logic [31:0] west0,
    output logic [31:0] west1,
    output logic [31:0] west2,
    output logic [31:0] west3,
    output logic [31:0] north0,
    output logic [31:0] north1,
    output logic [31:0] north2,
    output logic [31:0] north3,
    output logic        feed_valid,
    output logic [5:0]  count,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN} state_t;

    localparam logic [5:0] LAST_FEED  = 6'd6;
    // Final drain count; modulo 64 matches the wrap of the 6-bit counter.
    localparam logic [5:0] LAST_DRAIN = 6'((6 + DRAIN_CYCLES) % 64);
    localparam bit         NO_DRAIN   = (DRAIN_CYCLES == 0);

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [5:0]        count_q, count_d;
    logic              done_q, done_d;
    logic              feed_q, feed_d;
    logic [3:0][31:0]  west_q, west_d;
    logic [3:0][31:0]  north_q, north_d;

    // Matrix storage, indexed {row, col}; never reset.
    logic [31:0]       a_mem_q [16];
    logic [31:0]       b_mem_q [16];

    logic [31:0]       a_in [4];
    logic [31:0]       b_in [4];
    logic              accept;
    logic              wr_en;
    logic [1:0]        wr_row;

    assign a_in[0] = a0;
    assign a_in[1] = a1;
    assign a_in[2] = a2;
    assign a_in[3] = a3;
    assign b_in[0] = b0;
    assign b_in[1] = b1;
    assign b_in[2] = b2;
    assign b_in[3] = b3;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept   = in_valid && in_ready;
    assign wr_en    = accept && !clear;
    // A beat taken in IDLE is always row 0, whatever the beat counter holds.
    assign wr_row   = (state_q == S_IDLE) ? 2'd0 : beat_q;

    // Capture one row of A and B per accepted load beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < 4; c++) begin
                a_mem_q[{wr_row, 2'(c)}] <= a_in[c];
                b_mem_q[{wr_row, 2'(c)}] <= b_in[c];
            end
        end
    end

    // Next-state, beat counter, phase counter and completion pulse.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    beat_d  = 2'd1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = S_FEED;
                        count_d = 6'd0;
                    end
                end
            end
            S_FEED: begin
                count_d = count_q + 6'd1;
                if (count_q == LAST_FEED) begin
                    if (NO_DRAIN) begin
                        state_d = S_IDLE;
                        count_d = 6'd0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                count_d = count_q + 6'd1;
                if (count_q == LAST_DRAIN) begin
                    state_d = S_IDLE;
                    count_d = 6'd0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
            beat_d  = 2'd0;
            count_d = 6'd0;
            done_d  = 1'b0;
        end
    end

    assign feed_d = (state_d == S_FEED);

    // Skew: lane gi shows element (t - gi) of its row/column, zero outside 0..3.
    // Values are chosen from the next count so they land with that count.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [5:0] off;
        assign off         = count_d - 6'(gi);
        assign west_d[gi]  = (feed_d && off < 6'd4) ? a_mem_q[{2'(gi), off[1:0]}] : 32'h0;
        assign north_d[gi] = (feed_d && off < 6'd4) ? b_mem_q[{off[1:0], 2'(gi)}] : 32'h0;
    end

    // Control and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
            count_q <= 6'd0;
            done_q  <= 1'b0;
            feed_q  <= 1'b0;
            west_q  <= '0;
            north_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            count_q <= count_d;
            done_q  <= done_d;
            feed_q  <= feed_d;
            west_q  <= west_d;
            north_q <= north_d;
        end
    end

    assign west0      = west_q[0];
    assign west1      = west_q[1];
    assign west2      = west_q[2];
    assign west3      = west_q[3];
    assign north0     = north_q[0];
    assign north1     = north_q[1];
    assign north2     = north_q[2];
    assign north3     = north_q[3];
    assign feed_valid = feed_q;
    assign count      = count_q;
    assign busy       = (state_q == S_FEED) || (state_q == S_DRAIN);
    assign done       = done_q;

endmodule
